i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Shares one I2C master core between up to NREQ independent requesters, e.g. the APB register front end, a sensor-poll engine and a debug port. It picks one pending request by round robin and latches that requester's slave address, data byte and repeated-start flag. It then drives the master's enable and command inputs for the whole transaction and returns a per-requester completion or error pulse. It sits between the requesters and the I2C master's command port; only this block drives that port.

## Interface
- NREQ, 4: number of requesters, 2..8
- TIMEOUT, 1023: watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transaction request, level
- req_addr  in  8*NREQ  slave address byte per requester (bit 0 = R/W), slice i = [8i+7:8i]
- req_data  in  8*NREQ  write data byte per requester
- req_rstart  in  NREQ  repeated-start request per requester
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  NREQ  one-cycle error pulse (NACK or timeout), coincident with done
- m_enable  out  1  enable to the I2C master
- m_slave_address  out  8  latched address to the master
- m_data_in  out  8  latched data to the master
- m_repeated_start  out  1  latched repeated-start flag
- m_busy  in  1  master is running a transaction
- m_done  in  1  master finished, one-cycle pulse
- m_nack  in  1  master saw NACK; valid with m_done

## Operation
- All outputs are registered. The reset value of every output is 0. The pointer ptr resets to 0.
- Internal state: ptr is a $clog2(NREQ)-bit round-robin pointer; idx is the index of the granted requester.
- State machine IDLE -> LAUNCH -> RUN -> COMPLETE -> IDLE:
  - IDLE:
    - If |req, idx = the first set bit of req searching from ptr upward, wrapping at NREQ.
    - Latch that requester's address, data and rstart into the m_* outputs, set gnt[idx], go to LAUNCH.
    - With no request, stay in IDLE; outputs hold 0.
  - LAUNCH:
    - m_enable=1.
    - m_busy=1 -> RUN.
    - m_done=1 -> complete directly, as in RUN.
  - RUN:
    - m_enable stays 1.
    - On m_done: done[idx]=1 and err[idx]=m_nack for one cycle, then go to COMPLETE.
  - COMPLETE:
    - m_enable=0, gnt=0.
    - ptr <= (idx+1) mod NREQ, go to IDLE.
- The m_* command outputs stay stable from LAUNCH through COMPLETE. Changes on req_* after the grant are ignored.
- A requester that drops req mid-transaction does not abort the transaction; done still pulses.
- A requester that keeps req high after done is treated as a new request; ptr has already advanced, so other pending requesters win first.
- Arbitration is starvation-free: worst-case wait is NREQ-1 transactions.

## Timing
- req rises at edge k: gnt and m_* are valid after edge k+1, and m_enable after edge k+2.
- m_done at edge n: done/err are high in cycle n+1, gnt clears at n+2, and the earliest next gnt is at n+3.
- Minimum gap between transactions is 2 cycles (COMPLETE, IDLE).
- Reset mid-transaction: every output goes to 0 immediately and the block does not re-arm until rst_n rises. The master is released because m_enable drops.
- Simultaneous m_done and watchdog expiry: m_done wins; err reflects m_nack only.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - A 16-bit cycle counter clears on entering LAUNCH and counts in LAUNCH and RUN.
  - When it reaches TIMEOUT without m_done: pulse done[idx] and err[idx], go to COMPLETE (m_enable drops).
- Not defined: no counter; the block waits for m_done indefinitely.

## Test plan
- Single request: req=4'b0010, req_addr[15:8]=0xD7, req_data[15:8]=0xAA.
  - Expect gnt=4'b0010 and m_slave_address=0xD7, m_data_in=0xAA one cycle later; m_enable the cycle after.
  - m_done with m_nack=0 -> done=4'b0010 pulse, err=0, ptr=2.
- All four requesting continuously from reset: grant order 0,1,2,3,0. No gnt overlap; at least 2 idle cycles between grants.
- NACK: m_done with m_nack=1 -> done[idx]=1 and err[idx]=1 for exactly one cycle.
- Request dropped and req_data changed mid-RUN: m_data_in holds the latched value; done still pulses.
- rst_n low during RUN: gnt, m_enable, done and err are 0 within the same cycle; after release with req=4'b1000, the first grant goes to requester 3.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT=20: m_busy=1, no m_done -> err[idx] and done[idx] on cycle 20 after LAUNCH, m_enable low. Without the macro: still in RUN after 1000 cycles.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter sharing one I2C master between NREQ requesters
//
// Latches the winning requester's address, data and repeated-start flag, then drives
// the master's enable/command port for the whole transaction. Each transaction ends
// with a done pulse (and err on NACK) to the granted requester.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req                 per-requester request level
//   i_req_addr/data       8-bit slave address / write data per requester, slice i = [8i+7:8i]
//   i_req_rstart          per-requester repeated-start flag
//   o_gnt                 one-hot grant, held for the whole transaction
//   o_done / o_err        one-cycle completion / error pulse to the granted requester
//   o_m_*                 latched command to the I2C master plus its enable
//   i_m_busy/done/nack    master status
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to enable a TIMEOUT-cycle watchdog that
// ends a hung transaction with done+err.
module i2c_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_req_addr,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_rstart,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_done,
    output logic [NREQ-1:0]   o_err,
    output logic              o_m_enable,
    output logic [7:0]        o_m_slave_address,
    output logic [7:0]        o_m_data_in,
    output logic              o_m_repeated_start,
    input  logic              i_m_busy,
    input  logic              i_m_done,
    input  logic              i_m_nack
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, COMPLETE} state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_idx;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_j;
    logic          w_to;
    logic          w_fin;
    logic          w_nack;

    // Scan downward from ptr+NREQ-1 so the last hit is the closest set bit at or after ptr.
    always_comb begin
        w_sel = r_ptr;
        w_j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = PW'((int'(r_ptr) + k) % NREQ);
            if (i_req[w_j]) w_sel = w_j;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    assign w_to = (r_cnt == 16'(TIMEOUT - 1));
`else
    // Watchdog compiled out: transactions wait for m_done indefinitely.
    assign w_to = (TIMEOUT < 0);
`endif

    // A real m_done takes priority; a watchdog-only finish always reports an error.
    assign w_fin  = i_m_done | w_to;
    assign w_nack = i_m_done ? i_m_nack : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_ptr              <= '0;
            r_idx              <= '0;
            o_gnt              <= '0;
            o_done             <= '0;
            o_err              <= '0;
            o_m_enable         <= 1'b0;
            o_m_slave_address  <= '0;
            o_m_data_in        <= '0;
            o_m_repeated_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_cnt              <= '0;
`endif
        end else begin
            o_done <= '0;
            o_err  <= '0;
            case (r_state)
                IDLE: if (|i_req) begin
                    r_idx              <= w_sel;
                    o_gnt              <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
                    o_m_slave_address  <= i_req_addr[{w_sel, 3'b000} +: 8];
                    o_m_data_in        <= i_req_data[{w_sel, 3'b000} +: 8];
                    o_m_repeated_start <= i_req_rstart[w_sel];
                    r_state            <= LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
                    r_cnt              <= '0;
`endif
                end
                LAUNCH, RUN: begin
                    o_m_enable <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    r_cnt      <= r_cnt + 16'd1;
`endif
                    if (w_fin) begin
                        o_done  <= o_gnt;
                        o_err   <= o_gnt & {NREQ{w_nack}};
                        r_state <= COMPLETE;
                    end else if (r_state == LAUNCH && i_m_busy) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    o_m_enable         <= 1'b0;
                    o_gnt              <= '0;
                    o_m_slave_address  <= '0;
                    o_m_data_in        <= '0;
                    o_m_repeated_start <= 1'b0;
                    r_ptr              <= (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                    r_state            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: table-driven, random and corner-case bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_req;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_rstart;
    logic [3:0]  o_gnt, o_done, o_err;
    logic        o_m_enable;
    logic [7:0]  o_m_slave_address, o_m_data_in;
    logic        o_m_repeated_start;
    logic        i_m_busy, i_m_done, i_m_nack;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    i2c_txn_arbiter #(.NREQ(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .i_req_rstart(i_req_rstart),
        .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
        .o_m_enable(o_m_enable), .o_m_slave_address(o_m_slave_address),
        .o_m_data_in(o_m_data_in), .o_m_repeated_start(o_m_repeated_start),
        .i_m_busy(i_m_busy), .i_m_done(i_m_done), .i_m_nack(i_m_nack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rq;
        bit         hold;
        bit         nack;
        int         busy;
        int         idx;
        logic [7:0] a;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic int pick(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    task automatic do_txn(input logic [3:0] rq, input bit hold, input bit nack, input int busy,
                          input int ei, input logic [7:0] ea, input logic [7:0] ed);
        logic [3:0] eg;
        logic       er;
        eg = 4'b0001 << ei;
        for (int i = 0; i < 4; i++) begin
            i_req_addr[8*i +: 8] = 8'($urandom);
            i_req_data[8*i +: 8] = 8'($urandom);
            i_req_rstart[i]      = 1'($urandom);
        end
        i_req_addr[8*ei +: 8] = ea;
        i_req_data[8*ei +: 8] = ed;
        er    = i_req_rstart[ei];
        i_req = rq;
        @(negedge clk);
        chk("gnt", {28'd0, o_gnt}, {28'd0, eg});
        chk("m_addr", {24'd0, o_m_slave_address}, {24'd0, ea});
        chk("m_data", {24'd0, o_m_data_in}, {24'd0, ed});
        chk("m_rstart", {31'd0, o_m_repeated_start}, {31'd0, er});
        chk("en_early", {31'd0, o_m_enable}, 32'd0);
        if (!hold) i_req = '0;
        i_req_addr   = ~i_req_addr;
        i_req_data   = ~i_req_data;
        i_req_rstart = ~i_req_rstart;
        @(negedge clk);
        chk("enable", {31'd0, o_m_enable}, 32'd1);
        if (busy > 0) begin
            i_m_busy = 1'b1;
            repeat (busy) @(negedge clk);
        end
        chk("data_hold", {24'd0, o_m_data_in}, {24'd0, ed});
        chk("addr_hold", {24'd0, o_m_slave_address}, {24'd0, ea});
        i_m_done = 1'b1;
        i_m_nack = nack;
        @(negedge clk);
        i_m_done = 1'b0;
        i_m_nack = 1'b0;
        i_m_busy = 1'b0;
        chk("done", {28'd0, o_done}, {28'd0, eg});
        chk("err", {28'd0, o_err}, nack ? {28'd0, eg} : 32'd0);
        chk("gnt_hold", {28'd0, o_gnt}, {28'd0, eg});
        @(negedge clk);
        chk("done_clr", {28'd0, o_done}, 32'd0);
        chk("err_clr", {28'd0, o_err}, 32'd0);
        chk("gnt_clr", {28'd0, o_gnt}, 32'd0);
        chk("en_clr", {31'd0, o_m_enable}, 32'd0);
        m_ptr = (ei + 1) % 4;
    endtask

    initial begin
        int ei, c;
        logic [3:0] rq;
        tbl[0]  = '{4'b1111, 1, 0, 2, 0, 8'h12, 8'h34};
        tbl[1]  = '{4'b1111, 1, 0, 1, 1, 8'h56, 8'h78};
        tbl[2]  = '{4'b1111, 1, 1, 0, 2, 8'h9A, 8'hBC};
        tbl[3]  = '{4'b1111, 1, 0, 3, 3, 8'hDE, 8'hF0};
        tbl[4]  = '{4'b1111, 1, 0, 1, 0, 8'h01, 8'h02};
        tbl[5]  = '{4'b0010, 0, 0, 2, 1, 8'hD7, 8'hAA};
        tbl[6]  = '{4'b0011, 0, 1, 1, 0, 8'h3C, 8'hC3};
        tbl[7]  = '{4'b1000, 0, 0, 0, 3, 8'h81, 8'h18};
        tbl[8]  = '{4'b1001, 0, 1, 2, 0, 8'h44, 8'h55};
        tbl[9]  = '{4'b0101, 0, 0, 1, 2, 8'h66, 8'h77};
        tbl[10] = '{4'b0110, 0, 0, 1, 1, 8'hA5, 8'h5A};

        rst_n = 1'b0; i_req = '0; i_req_addr = '0; i_req_data = '0; i_req_rstart = '0;
        i_m_busy = 1'b0; i_m_done = 1'b0; i_m_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {28'd0, o_gnt}, 32'd0);
        chk("rst_en", {31'd0, o_m_enable}, 32'd0);
        chk("rst_done", {28'd0, o_done | o_err}, 32'd0);
        chk("rst_cmd", {15'd0, o_m_repeated_start, o_m_slave_address, o_m_data_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", {28'd0, o_gnt}, 32'd0);

        for (int t = 0; t < 11; t++)
            do_txn(tbl[t].rq, tbl[t].hold, tbl[t].nack, tbl[t].busy, tbl[t].idx, tbl[t].a, tbl[t].d);

        for (int t = 0; t < 40; t++) begin
            rq = 4'($urandom_range(1, 15));
            ei = pick(m_ptr, rq);
            do_txn(rq, 1'($urandom), 1'($urandom), $urandom_range(0, 3), ei, 8'($urandom), 8'($urandom));
        end

        rq = 4'b0100;
        ei = pick(m_ptr, rq);
        i_req = rq;
        @(negedge clk);
        chk("wd_gnt", {28'd0, o_gnt}, {28'd0, 4'b0001 << ei});
        i_req = '0;
        i_m_busy = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
        c = 0;
        for (int n = 1; n <= 30 && c == 0; n++) begin
            @(negedge clk);
            if (o_err != 0) c = n;
        end
        chk("wd_cycle", c, 20);
        chk("wd_done", {28'd0, o_done}, {28'd0, 4'b0001 << ei});
        chk("wd_err", {28'd0, o_err}, {28'd0, 4'b0001 << ei});
        @(negedge clk);
        chk("wd_en", {31'd0, o_m_enable}, 32'd0);
        i_m_busy = 1'b0;
`else
        c = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (o_done != 0) c++;
        end
        chk("nowd_done", c, 0);
        chk("nowd_gnt", {28'd0, o_gnt}, {28'd0, 4'b0001 << ei});
        chk("nowd_en", {31'd0, o_m_enable}, 32'd1);
        i_m_done = 1'b1;
        @(negedge clk);
        i_m_done = 1'b0;
        i_m_busy = 1'b0;
        chk("nowd_fin", {28'd0, o_done}, {28'd0, 4'b0001 << ei});
`endif
        @(negedge clk);
        m_ptr = (ei + 1) % 4;

        i_req = 4'b0001;
        @(negedge clk);
        i_req = '0;
        @(negedge clk);
        i_m_busy = 1'b1;
        @(negedge clk);
        chk("pre_rst_en", {31'd0, o_m_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", {28'd0, o_gnt}, 32'd0);
        chk("mid_rst_en", {31'd0, o_m_enable}, 32'd0);
        chk("mid_rst_pulse", {28'd0, o_done | o_err}, 32'd0);
        i_m_busy = 1'b0;
        i_req = 4'b1111;
        @(negedge clk);
        chk("rst_hold_gnt", {28'd0, o_gnt}, 32'd0);
        i_req = '0;
        rst_n = 1'b1;
        do_txn(4'b1000, 0, 0, 1, 3, 8'hC8, 8'h8C);
        do_txn(4'b0011, 0, 0, 1, 0, 8'h11, 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
